// File: rtl/instr_encoder_loader.sv
// Instruction encoder / loader.
// Accepts one decoded instruction beat at a time, packs it into a 32-bit RV32
// word and writes it to instruction memory at consecutive word addresses
// starting at BASE_ADDR. It stops when the program's last beat is written or
// the memory is full.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [12:0] in_imm,
  input  logic        in_last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        restart,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic        armed;     // low until the first edge after reset
  logic        last_q;    // in_last captured with the pending word
  logic        err_q;
  logic [15:0] count_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        legal;
  logic        ack_fire;
  logic [15:0] count_inc;
  logic        full;

  // Pack the instruction fields into the RV32 word for the given type.
  function automatic logic [31:0] encode(
    input logic [2:0]  typ,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [12:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (typ)
      3'd0:    w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'd1:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd2:    w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      3'd3:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      3'd4:    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign legal     = (in_type <= 3'd4);
  assign in_ready  = armed && (state == IDLE) && !restart;
  assign accept    = in_valid && in_ready;
  assign ack_fire  = (state == WRITE) && mem_ack;
  assign count_inc = count_q + 16'd1;
  assign full      = (count_inc == MAX_CNT);

  assign mem_we    = (state == WRITE);
  assign mem_addr  = BASE_ADDR + {14'd0, count_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign done      = (state == DONE);
  assign err       = err_q;
  assign count     = count_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; restart overrides everything.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    if (restart) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && legal) state_nx = WRITE;
        WRITE:   if (mem_ack) state_nx = (last_q || full) ? DONE : IDLE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath: captured word, word counter, sticky error and ready arming.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured word is reset too, because mem_wdata must read 0
    // during reset; it is a single register, not a memory array.
    if (!rst_n) begin
      armed   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      wdata_q <= '0;
    end else begin
      armed <= 1'b1;
      if (restart) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (accept) begin
          if (legal) begin
            wdata_q <= encode(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            last_q  <= in_last;
          end else begin
            err_q <= 1'b1;
          end
        end
        if (ack_fire) begin
          count_q <= count_inc;
          // Memory filled before the program ended: overflow.
          if (full && !last_q) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (default size, and a 2-word
// memory at a non-zero base) share all inputs. A transaction-level model
// predicts every output, checked on each falling edge; directed scenarios add
// literal expectations, then randomized traffic runs against the model.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_type = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [12:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        mem_ack = 1'b0;
  logic        restart = 1'b0;

  logic        rdy   [2];
  logic        we    [2];
  logic        done  [2];
  logic        err   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [15:0] cnt   [2];

  int n_tests = 0;
  int n_fail  = 0;

  instr_encoder_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(256)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_ack(mem_ack), .restart(restart),
    .done(done[0]), .err(err[0]), .count(cnt[0])
  );

  instr_encoder_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_ack(mem_ack), .restart(restart),
    .done(done[1]), .err(err[1]), .count(cnt[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int max_of(input int i);
    return (i == 0) ? 256 : 2;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? BASE0 : BASE1;
  endfunction

  // Field placement by shift-and-or from the instruction format tables.
  function automatic logic [31:0] model_enc(input logic [2:0] t, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [12:0] imm);
    logic [31:0] im, w;
    im = 32'(imm);
    w  = (32'(f3) << 12) | (32'(rs1) << 15);
    case (t)
      3'd0: w = w | ((im & 32'hfff) << 20) | (32'(rd) << 7) | 32'h03;
      3'd1: w = w | (((im >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | ((im & 32'h1f) << 7) | 32'h23;
      3'd2: w = w | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7) | 32'h33;
      3'd3: w = w | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3f) << 25)
                  | (32'(rs2) << 20) | (((im >> 1) & 32'hf) << 8)
                  | (((im >> 11) & 32'h1) << 7) | 32'h63;
      3'd4: w = w | ((im & 32'hfff) << 20) | (32'(rd) << 7) | 32'h13;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  bit          m_armed [2];
  bit          m_pend  [2];   // a word is waiting for its ack
  bit          m_done  [2];
  bit          m_err   [2];
  bit          m_last  [2];
  int          m_cnt   [2];
  logic [31:0] m_word  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_armed[i] <= 1'b0; m_pend[i] <= 1'b0; m_done[i] <= 1'b0;
        m_err[i]   <= 1'b0; m_last[i] <= 1'b0; m_cnt[i]  <= 0;
        m_word[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit ready_v;
        int nc;
        ready_v = m_armed[i] && !m_pend[i] && !m_done[i] && !restart;
        nc      = m_cnt[i] + 1;
        m_armed[i] <= 1'b1;
        if (restart) begin
          m_cnt[i] <= 0; m_err[i] <= 1'b0; m_done[i] <= 1'b0; m_pend[i] <= 1'b0;
        end else if (m_pend[i]) begin
          if (mem_ack) begin
            m_cnt[i]  <= nc;
            m_pend[i] <= 1'b0;
            if (m_last[i] || nc == max_of(i)) m_done[i] <= 1'b1;
            if (nc == max_of(i) && !m_last[i]) m_err[i] <= 1'b1;
          end
        end else if (ready_v && in_valid) begin
          if (in_type <= 3'd4) begin
            m_pend[i] <= 1'b1;
            m_word[i] <= model_enc(in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            m_last[i] <= in_last;
          end else begin
            m_err[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d_in_ready", i), 32'(rdy[i]),
            32'(m_armed[i] && !m_pend[i] && !m_done[i] && !restart));
      check($sformatf("d%0d_mem_we", i), 32'(we[i]), 32'(m_pend[i]));
      check($sformatf("d%0d_done", i), 32'(done[i]), 32'(m_done[i]));
      check($sformatf("d%0d_err", i), 32'(err[i]), 32'(m_err[i]));
      check($sformatf("d%0d_count", i), 32'(cnt[i]), 32'(m_cnt[i]));
      check($sformatf("d%0d_mem_addr", i), addr[i], base_of(i) + 32'(4 * m_cnt[i]));
      if (m_pend[i] || !rst_n)
        check($sformatf("d%0d_mem_wdata", i), wdata[i], m_word[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [12:0] imm, input logic last);
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, sampled asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_mem_we", 32'(we[0]), 32'd0);
    check("rst_mem_addr", addr[0], BASE0);
    check("rst_mem_addr1", addr[1], BASE1);
    check("rst_mem_wdata", wdata[0], 32'd0);
    check("rst_count", 32'(cnt[0]), 32'd0);
    check("rst_flags", {29'd0, done[0], err[0], rdy[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", 32'(rdy[0]), 32'd0);
    tick();
    @(negedge clk);
    check("ready_after_first_edge", 32'(rdy[0]), 32'd1);
    tick();

    // LOAD with ack tied high.
    mem_ack = 1'b1;
    beat(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 1'b0);
    @(negedge clk);
    check("load_we", 32'(we[0]), 32'd1);
    check("load_addr", addr[0], 32'h0);
    check("load_wdata", wdata[0], 32'h0081_2283);
    tick();
    @(negedge clk);
    check("load_count", 32'(cnt[0]), 32'd1);
    check("load_addr_next", addr[0], 32'h4);
    tick();

    // RTYPE then STORE with in_last.
    pulse_restart();
    beat(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
    @(negedge clk);
    check("rtype_wdata", wdata[0], 32'h0020_81B3);
    check("rtype_addr", addr[0], 32'h0);
    tick();
    beat(3'd1, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'd12, 1'b1);
    @(negedge clk);
    check("store_wdata", wdata[0], 32'h0020_A623);
    check("store_addr", addr[0], 32'h4);
    tick();
    @(negedge clk);
    check("prog_done", 32'(done[0]), 32'd1);
    check("prog_count", 32'(cnt[0]), 32'd2);
    tick();

    // BRANCH with ack withheld for three cycles.
    pulse_restart();
    mem_ack = 1'b0;
    beat(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("branch_hold%0d", k), {we[0], 15'd0, cnt[0]}, 32'h8000_0000);
      check($sformatf("branch_wdata%0d", k), wdata[0], 32'h0020_8463);
      tick();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    check("branch_hold3", {we[0], 15'd0, cnt[0]}, 32'h8000_0000);
    check("branch_wdata3", wdata[0], 32'h0020_8463);
    tick();
    @(negedge clk);
    check("branch_after_ack", {we[0], 15'd0, cnt[0]}, 32'h0000_0001);
    tick();

    // Illegal type, then a legal beat at the same address.
    pulse_restart();
    beat(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0, 1'b0);
    @(negedge clk);
    check("illegal_err", 32'(err[0]), 32'd1);
    check("illegal_no_we", 32'(we[0]), 32'd0);
    check("illegal_count", 32'(cnt[0]), 32'd0);
    tick();
    beat(3'd4, 5'd7, 5'd3, 5'd0, 3'd1, 7'd0, 13'h0123, 1'b0);
    @(negedge clk);
    check("itype_wdata", wdata[0], 32'h1231_9393);
    check("itype_addr", addr[0], 32'h0);
    check("itype_we", 32'(we[0]), 32'd1);
    tick();

    // Overflow on the 2-word instance: three beats, none last.
    pulse_restart();
    for (int k = 0; k < 2; k++) begin
      beat(3'd2, 5'(k + 1), 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
      tick();
    end
    @(negedge clk);
    check("ovf_done", 32'(done[1]), 32'd1);
    check("ovf_err", 32'(err[1]), 32'd1);
    check("ovf_count", 32'(cnt[1]), 32'd2);
    check("ovf_addr", addr[1], BASE1 + 32'd8);
    #1;
    in_type = 3'd0; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("ovf_third_ready", 32'(rdy[1]), 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("ovf_third_ignored", {we[1], 15'd0, cnt[1]}, 32'h0000_0002);
    tick();

    // Reset during WRITE, then restart while DONE.
    pulse_restart();
    mem_ack = 1'b0;
    beat(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'd4, 1'b0);
    @(negedge clk);
    check("pre_reset_we", 32'(we[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(we[0]), 32'd0);
    check("async_rst_addr", addr[0], BASE0);
    check("async_rst_wdata", wdata[0], 32'd0);
    check("async_rst_count", 32'(cnt[0]), 32'd0);
    check("async_rst_flags", {29'd0, done[0], err[0], rdy[0]}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1;
    beat(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'd4, 1'b1);
    tick();
    @(negedge clk);
    check("pre_restart_done", 32'(done[0]), 32'd1);
    tick();
    pulse_restart();
    @(negedge clk);
    check("restart_done", 32'(done[0]), 32'd0);
    check("restart_count", 32'(cnt[0]), 32'd0);
    check("restart_addr0", addr[0], BASE0);
    check("restart_addr1", addr[1], BASE1);
    check("restart_ready", 32'(rdy[0]), 32'd1);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_type   = 3'($urandom_range(0, 7));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_imm    = 13'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      mem_ack   = ($urandom_range(0, 2) != 0);
      restart   = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      tick();
    end
    in_valid = 1'b0;
    restart  = 1'b0;
    rst_n    = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first word written.
REQ-002 The module SHALL have parameter MAX_WORDS, default 256, meaning the word capacity of the target instruction memory.
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit, meaning the instruction-field beat is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the module accepts a beat this cycle.
REQ-007 The module SHALL have port in_type, input, 3 bits, meaning 0=LOAD, 1=STORE, 2=RTYPE, 3=BRANCH, 4=ITYPE, 5..7=illegal.
REQ-008 The module SHALL have ports in_rd, in_rs1 and in_rs2, input, 5 bits each, meaning the register indices.
REQ-009 The module SHALL have port in_funct3, input, 3 bits, meaning funct3.
REQ-010 The module SHALL have port in_funct7, input, 7 bits, meaning funct7 (RTYPE only).
REQ-011 The module SHALL have port in_imm, input, 13 bits, meaning the immediate: BRANCH uses [12:1] with [0] ignored, and all other types use [11:0].
REQ-012 The module SHALL have port in_last, input, 1 bit, meaning the final instruction of the program.
REQ-013 The module SHALL have port mem_we, output, 1 bit, meaning the write request.
REQ-014 The module SHALL have port mem_addr, output, 32 bits, meaning the write byte address.
REQ-015 The module SHALL have port mem_wdata, output, 32 bits, meaning the encoded instruction word.
REQ-016 The module SHALL have port mem_ack, input, 1 bit, meaning the memory accepted the write this cycle.
REQ-017 The module SHALL have port restart, input, 1 bit, meaning a single-cycle pulse that rearms the loader.
REQ-018 The module SHALL have port done, output, 1 bit, meaning program load is complete.
REQ-019 The module SHALL have port err, output, 1 bit, meaning sticky: an illegal type was received or an overflow occurred.
REQ-020 The module SHALL have port count, output, 16 bits, meaning the number of words written since reset or restart.

Function
REQ-021 The module SHALL implement FSM states IDLE, WRITE and DONE.
REQ-022 The module SHALL drive in_ready=1 only in IDLE; a beat is accepted on an edge where in_valid and in_ready are both 1.
REQ-023 On acceptance of a legal type, the module SHALL register the encoded word and go to WRITE, with mem_we=1 in the next cycle (latency 1).
REQ-024 The module SHALL encode LOAD as imm[11:0]|rs1|funct3|rd|7'b0000011.
REQ-025 The module SHALL encode STORE as imm[11:5]|rs2|rs1|funct3|imm[4:0]|7'b0100011.
REQ-026 The module SHALL encode RTYPE as funct7|rs2|rs1|funct3|rd|7'b0110011.
REQ-027 The module SHALL encode BRANCH as imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|7'b1100011.
REQ-028 The module SHALL encode ITYPE as imm[11:0]|rs1|funct3|rd|7'b0010011.
REQ-029 In WRITE, the module SHALL hold mem_we, mem_addr and mem_wdata stable until the edge with mem_ack=1, and SHALL NOT time out.
REQ-030 On the mem_ack edge, the module SHALL increment count and advance mem_addr by 4, then go to DONE if the captured in_last=1 or the new count equals MAX_WORDS, and to IDLE otherwise.
REQ-031 mem_addr SHALL equal BASE_ADDR + 4*count at all times.
REQ-032 On acceptance of an illegal type (5..7), the module SHALL set err, perform no write, leave count unchanged and remain in IDLE.
REQ-033 If the module reaches DONE because count equals MAX_WORDS while the captured in_last=0, it SHALL set err.
REQ-034 In DONE, the module SHALL hold done=1 and in_ready=0, and SHALL ignore in_valid.
REQ-035 A restart pulse in any state SHALL clear count, done and err and move to IDLE, with mem_addr=BASE_ADDR on the next cycle; a restart during WRITE SHALL abandon that write by dropping mem_we on the next cycle.
REQ-036 mem_we SHALL be 1 only in WRITE.

Reset
REQ-037 While rst_n=0, the module SHALL immediately force state to IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, err=0 and in_ready=0.
REQ-038 The module SHALL drive in_ready=1 from the first clock edge after rst_n deasserts, and a reset asserted mid-WRITE SHALL abort that write with no count increment.

Verification
REQ-039 The bench SHALL cover: LOAD rd=5, rs1=2, funct3=2, imm=8, mem_ack tied to 1 -> mem_wdata=32'h00812283, mem_addr=0, mem_we=1 in the cycle after acceptance, then count=1.
REQ-040 The bench SHALL cover: RTYPE rd=3, rs1=1, rs2=2, funct3=0, funct7=0, then STORE rs1=1, rs2=2, funct3=2, imm=12 with in_last=1 -> words 32'h002081B3 at address 0 and 32'h0020A623 at address 4, followed by done=1.
REQ-041 The bench SHALL cover: BRANCH rs1=1, rs2=2, funct3=0, imm=8 with mem_ack withheld for 3 cycles -> mem_wdata=32'h00208463 held stable with mem_we=1 for 4 cycles, count unchanged until the ack edge.
REQ-042 The bench SHALL cover: in_type=6 -> err=1, no mem_we, count unchanged; the next legal beat still writes at the same address.
REQ-043 The bench SHALL cover: MAX_WORDS=2 with three beats, none having in_last=1 -> two writes, done=1, err=1, and in_ready=0 for the third beat.
REQ-044 The bench SHALL cover: rst_n asserted during WRITE, followed by restart in DONE -> outputs take reset values asynchronously, count=0, mem_addr=BASE_ADDR.
